// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps
// bracketed by an operand-latch cycle and a sign/special-case fix-up cycle.
module mul_div_unit #(
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = 5,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  input  logic [IDX_WIDTH-1:0] rd_index_in,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [IDX_WIDTH-1:0] rd_index_out
);

  localparam int DW = 2 * WIDTH;

  // Handshake: start is sampled only in IDLE; busy covers CALC..DONE; done
  // pulses for the single DONE cycle, when result/rd_index_out are valid.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           op_q;
  logic [IDX_WIDTH-1:0] rd_q;
  logic [WIDTH-1:0]     m_q;
  logic [DW-1:0]        acc_q, acc_d;
  logic [WIDTH-1:0]     a_raw_q;
  logic                 neg_q, rem_neg_q, div_zero_q, ovf_q;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [IDX_WIDTH-1:0] rd_out_q;

  logic                 sign_a_en, sign_b_en, a_neg, b_neg, is_div;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 last_iter;

  logic [WIDTH:0]       mul_sum;
  logic [DW-1:0]        mul_next, div_next;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_sub;

  logic [DW-1:0]        prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;

  // Signedness per funct3: MUL/MULH/DIV/REM signed a and b, MULHSU signed a only.
  assign is_div    = op[2];
  assign sign_a_en = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign sign_b_en = op[2] ? ~op[0] : ~op[1];
  assign a_neg     = sign_a_en & operand_a[WIDTH-1];
  assign b_neg     = sign_b_en & operand_b[WIDTH-1];
  assign a_mag     = a_neg ? -operand_a : operand_a;
  assign b_mag     = b_neg ? -operand_b : operand_b;
  assign last_iter = (cnt_q == CNT_WIDTH'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (last_iter) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_CALC, S_FIX: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // acc holds {product_hi, multiplier} for multiply, {remainder, quotient} for divide.
  assign mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_ge   = acc_q[DW-1:WIDTH-1] >= {1'b0, m_q};
  assign div_sub  = acc_q[DW-2:WIDTH-1] - m_q;
  assign div_next = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1} : {acc_q[DW-2:0], 1'b0};

  assign prod_fix = neg_q ? -acc_q : acc_q;

  always_comb begin
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];
    if (div_zero_q) begin
      quot_fix = '1;
      rem_fix  = a_raw_q;
    end else if (ovf_q) begin
      quot_fix = {1'b1, {(WIDTH-1){1'b0}}};
      rem_fix  = '0;
    end
  end

  always_comb begin
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (state_q == S_CALC) begin
      acc_d = op_q[2] ? div_next : mul_next;
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == S_FIX) begin
      case (op_q)
        3'b000:         result_d = prod_fix[WIDTH-1:0];
        3'b100, 3'b101: result_d = quot_fix;
        3'b110, 3'b111: result_d = rem_fix;
        default:        result_d = prod_fix[DW-1:WIDTH];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      m_q        <= '0;
      acc_q      <= '0;
      a_raw_q    <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      rd_out_q   <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        cnt_q      <= '0;
        op_q       <= op;
        rd_q       <= rd_index_in;
        m_q        <= is_div ? b_mag : a_mag;
        acc_q      <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
        a_raw_q    <= operand_a;
        neg_q      <= a_neg ^ b_neg;
        rem_neg_q  <= a_neg;
        div_zero_q <= (operand_b == '0);
        ovf_q      <= sign_b_en && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (operand_b == '1);
      end
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      if (state_q == S_FIX) rd_out_q <= rd_q;
    end
  end

  assign result       = result_q;
  assign rd_index_out = rd_out_q;

endmodule
